// File: rtl/uart_frame_parser.sv
// uart_frame_parser: framer behind the UART receiver.
// Collects SOF, LEN, LEN payload bytes, CHK; releases the buffered payload on a
// valid/ready stream only after the checksum matches. Malformed, corrupted and
// stalled frames are dropped with a one-cycle frame_err pulse and a held code.
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pld_data,
  output logic       pld_valid,
  input  logic       pld_ready,
  output logic       pld_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    mem [0:(2**PW)-1];

  logic          in_frame;
  logic          timed_out;
  logic          len_bad;
  logic          last_wr;
  logic          last_rd;
  logic          xfer;
  logic          err_set;
  logic [1:0]    err_val;
  logic          done;

  // The inter-byte timer only matters while a frame is being received.
  assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign timed_out = in_frame && !rx_valid && (idle_cnt == TO_LAST);
  assign len_bad   = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);
  assign last_wr   = (8'(wr_ptr) == (len - 8'd1));
  assign last_rd   = (8'(rd_ptr) == (len - 8'd1));

  // The buffer read is combinational, so data and last stay put while stalled.
  assign pld_valid = (state == S_DRAIN);
  assign pld_data  = pld_valid ? mem[rd_ptr] : 8'h00;
  assign pld_last  = pld_valid && last_rd;
  assign xfer      = pld_valid && pld_ready;

  // Next-state decode plus the error/done strobes that feed the pulse registers.
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_val  = 2'd0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SOF_BYTE)) state_nx = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (len_bad) begin
            err_set  = 1'b1;
            err_val  = 2'd1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_PAYLOAD;
          end
        end else if (timed_out) begin
          err_set  = 1'b1;
          err_val  = 2'd3;
          state_nx = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          if (last_wr) state_nx = S_CHK;
        end else if (timed_out) begin
          err_set  = 1'b1;
          err_val  = 2'd3;
          state_nx = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == sum) begin
            state_nx = S_DRAIN;
          end else begin
            err_set  = 1'b1;
            err_val  = 2'd2;
            state_nx = S_IDLE;
          end
        end else if (timed_out) begin
          err_set  = 1'b1;
          err_val  = 2'd3;
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (xfer && last_rd) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Frame bookkeeping: length, running checksum, pointers, timer and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= 8'd0;
      sum       <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idle_cnt  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      frame_ok  <= done;
      frame_err <= err_set;
      if (err_set) err_code <= err_val;
      if ((state == S_DRAIN) && rx_valid) overrun <= 1'b1;

      if ((state == S_IDLE) || rx_valid || !in_frame) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_LEN: begin
          if (rx_valid) begin
            len    <= rx_data;
            sum    <= rx_data;
            wr_ptr <= '0;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            sum    <= sum + rx_data;
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        S_CHK: begin
          if (rx_valid) rd_ptr <= '0;
        end
        S_DRAIN: begin
          if (xfer) rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload storage; contents are only meaningful between LEN and the end of DRAIN.
  always_ff @(posedge clk) begin
    if ((state == S_PAYLOAD) && rx_valid) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with MAX_LEN=16 and TIMEOUT_CYCLES=50.
module tb_uart_frame_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic       pld_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  uart_frame_parser #(
    .SOF_BYTE      (8'hA5),
    .MAX_LEN       (16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pld_data (pld_data),
    .pld_valid(pld_valid),
    .pld_ready(pld_ready),
    .pld_last (pld_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q[$];
  int         qc[$];
  int         cyc = 0;
  int         n_ok = 0;
  int         n_err = 0;
  int         n_stall = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records transfers, pulses and stall stability at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        if (!pld_valid || (pld_data !== prev_data) || (pld_last !== prev_last))
          stall_viol++;
      end
      if (pld_valid && pld_ready) begin
        q.push_back({pld_last, pld_data});
        qc.push_back(cyc);
      end
      if (pld_valid && !pld_ready) n_stall++;
      prev_stall = pld_valid && !pld_ready;
      prev_data  = pld_data;
      prev_last  = pld_last;
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [8:0] qget(input int i);
    if (i < q.size()) return q[i];
    return 9'h1FF;
  endfunction

  function automatic int qcyc(input int i);
    if (i < qc.size()) return qc[i];
    return -100;
  endfunction

  task automatic clear_mon();
    q.delete();
    qc.delete();
    n_ok       = 0;
    n_err      = 0;
    n_stall    = 0;
    stall_viol = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_good();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
  endtask

  task automatic check_good(input string tag);
    check({tag, "_cnt"}, q.size(), 3);
    check({tag, "_b0"}, qget(0), 9'h011);
    check({tag, "_b1"}, qget(1), 9'h022);
    check({tag, "_b2"}, qget(2), 9'h133);
    check({tag, "_ok"}, n_ok, 1);
    check({tag, "_err"}, n_err, 0);
  endtask

  int k;
  int seen;

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    pld_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // reset state
    check("rst_valid", pld_valid, 0);
    check("rst_data", pld_data, 0);
    check("rst_last", pld_last, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_ovr", overrun, 0);

    // good frame, consecutive beats
    clear_mon();
    send_good();
    tick(6);
    check_good("good");
    check("good_gap1", qcyc(1) - qcyc(0), 1);
    check("good_gap2", qcyc(2) - qcyc(1), 1);

    // bad checksum, then recovery
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
    tick(3);
    check("badchk_cnt", q.size(), 0);
    check("badchk_err", n_err, 1);
    check("badchk_code", err_code, 2);
    check("badchk_ok", n_ok, 0);
    clear_mon();
    send_good();
    tick(6);
    check_good("recov");

    // bad lengths, then maximum length
    clear_mon();
    send(8'hA5); send(8'h00);
    tick(2);
    check("len0_err", n_err, 1);
    check("len0_code", err_code, 1);
    send(8'hA5); send(8'h11);
    tick(2);
    check("len17_err", n_err, 2);
    check("len17_code", err_code, 1);
    clear_mon();
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h98);
    tick(20);
    check("len16_cnt", q.size(), 16);
    check("len16_first", qget(0), 9'h001);
    check("len16_mid", qget(7), 9'h008);
    check("len16_last", qget(15), 9'h110);
    check("len16_ok", n_ok, 1);
    check("len16_err", n_err, 0);

    // noise then backpressure 1,0,0,1,0,1
    clear_mon();
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    pld_ready = 1'b1; tick(1);
    pld_ready = 1'b0; tick(1);
    pld_ready = 1'b0; tick(1);
    pld_ready = 1'b1; tick(1);
    pld_ready = 1'b0; tick(1);
    pld_ready = 1'b1; tick(1);
    tick(4);
    check_good("bp");
    check("bp_stalls", n_stall, 3);
    check("bp_stable", stall_viol, 0);

    // timeout after silence
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11);
    seen = 0;
    for (k = 1; k <= 60; k++) begin
      tick(1);
      if (frame_err && seen == 0) seen = k;
    end
    check("to_delay", seen, 50);
    check("to_code", err_code, 3);
    check("to_err", n_err, 1);
    check("to_cnt", q.size(), 0);

    // byte arriving on the last possible cycle keeps the frame alive
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11);
    tick(49);
    send(8'h22);
    send(8'h33); send(8'h69);
    tick(6);
    check_good("to_edge");

    // overrun while draining with ready low
    clear_mon();
    pld_ready = 1'b0;
    send_good();
    check("ovr_pre", overrun, 0);
    send(8'h00);
    check("ovr_set", overrun, 1);
    tick(3);
    check("ovr_hold_valid", pld_valid, 1);
    check("ovr_hold_data", pld_data, 8'h11);
    pld_ready = 1'b1;
    tick(6);
    check_good("ovr");
    check("ovr_sticky", overrun, 1);

    // asynchronous reset mid-payload
    clear_mon();
    send(8'hA5); send(8'h03); send(8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ovr", overrun, 0);
    check("arst_code", err_code, 0);
    check("arst_valid", pld_valid, 0);
    check("arst_err", frame_err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_good();
    tick(6);
    check_good("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
